// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit calculator controller: data width,
// opcode encodings and the controller state enumeration.
package calc_pkg;

    localparam int DW = 4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MUL  = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/addsub4.sv
// Shared 4-bit adder/subtractor: A + (B ^ {sub}) + sub, with carry-out and
// signed-overflow flags.
module addsub4
    import calc_pkg::*;
(
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_sub,
    output logic [DW-1:0] o_sum,
    output logic          o_carry,
    output logic          o_ovf
);

    logic [DW-1:0] w_b;
    logic [DW:0]   w_full;

    assign w_b     = i_b ^ {DW{i_sub}};
    assign w_full  = {1'b0, i_a} + {1'b0, w_b} + {{DW{1'b0}}, i_sub};
    assign o_sum   = w_full[DW-1:0];
    assign o_carry = w_full[DW];
    // Overflow when both addend signs agree but the result sign differs.
    assign o_ovf   = (i_a[DW-1] == w_b[DW-1]) && (o_sum[DW-1] != i_a[DW-1]);

endmodule

// File: rtl/calc_ctrl4.sv
// Accumulator calculator controller: LOAD/ADD/SUB in one EXEC cycle, MUL by
// repeated addition, all through a single shared addsub4 datapath.
module calc_ctrl4
    import calc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [DW-1:0] operand,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] acc,
    output logic          cout,
    output logic          ovf
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ready;
    logic          r_done;
    logic [1:0]    r_op;
    logic [DW-1:0] r_operand;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_prod;
    logic [DW-1:0] r_mcand;
    logic [DW-1:0] r_cnt;
    logic          r_mul_c;
    logic          r_cout;
    logic          r_ovf;

    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic          w_sub;
    logic [DW-1:0] w_sum;
    logic          w_carry;
    logic          w_ovf;

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (op == OP_MUL) ? S_MUL : S_EXEC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EXEC: w_state_nxt = S_DONE;
            S_MUL: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_MUL;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; ready/done are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    // Datapath operand mux: MUL accumulates prod + mcand, EXEC uses acc/operand.
    always_comb begin
        w_a   = r_acc;
        w_b   = r_operand;
        w_sub = 1'b0;
        if (r_state == S_MUL) begin
            w_a = r_prod;
            w_b = r_mcand;
        end else begin
            w_sub = (r_op == OP_SUB);
        end
    end

    addsub4 u_addsub4 (
        .i_a     (w_a),
        .i_b     (w_b),
        .i_sub   (w_sub),
        .o_sum   (w_sum),
        .o_carry (w_carry),
        .o_ovf   (w_ovf)
    );

    // Operand latching, accumulator/flag updates and the multiply loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op      <= OP_LOAD;
            r_operand <= 4'd0;
            r_acc     <= 4'd0;
            r_prod    <= 4'd0;
            r_mcand   <= 4'd0;
            r_cnt     <= 4'd0;
            r_mul_c   <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op      <= op;
                        r_operand <= operand;
                        if (op == OP_MUL) begin
                            r_mcand <= r_acc;
                            r_cnt   <= operand;
                            r_prod  <= 4'd0;
                            r_mul_c <= 1'b0;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_op == OP_LOAD) begin
                        r_acc  <= r_operand;
                        r_cout <= 1'b0;
                        r_ovf  <= 1'b0;
                    end else begin
                        r_acc  <= w_sum;
                        r_cout <= w_carry;
                        r_ovf  <= w_ovf;
                    end
                end
                S_MUL: begin
                    if (r_cnt != 4'd0) begin
                        r_prod  <= w_sum;
                        r_cnt   <= r_cnt - 4'd1;
                        r_mul_c <= r_mul_c | w_carry;
                    end else begin
                        r_acc  <= r_prod;
                        r_cout <= r_mul_c;
                        r_ovf  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign acc   = r_acc;
    assign cout  = r_cout;
    assign ovf   = r_ovf;

endmodule
